// File: rtl/fu_pkg.sv
// Shared issue-control types: functional-unit select, writeback entry, routing helper.
package fu_pkg;
    import opcode_pkg::*;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_DIV = 2'd2
    } fu_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        fu_sel_t    src;
    } wb_entry_t;

    typedef enum logic [1:0] {
        RT_ALU = 2'd0,
        RT_MUL = 2'd1,
        RT_DIV = 2'd2,
        RT_ILL = 2'd3
    } route_t;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    // Map an instruction onto the unit that executes it; RT_ILL means unhandled.
    function automatic route_t fu_route(input logic [2:0] opc, input logic [4:0] f5,
                                        input logic div_en);
        route_t r;
        r = RT_ILL;
        case (opc)
            R_TYPE, I_TYPE, F_TYPE, X_TYPE: begin
                if (f5 == MUL)                    r = RT_MUL;
                else if (f5 == DIV || f5 == SQRT) r = div_en ? RT_DIV : RT_ILL;
                else                              r = RT_ALU;
            end
            U_TYPE:  r = RT_ALU;
            default: r = RT_ILL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/opcode_pkg.sv
// Decoder-facing encodings: instruction class (opc_t) and function code (func5_t).
package opcode_pkg;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        F_TYPE = 3'd2,
        X_TYPE = 3'd3,
        U_TYPE = 3'd4,
        M_TYPE = 3'd5,
        D_TYPE = 3'd6,
        C_TYPE = 3'd7
    } opc_t;

    typedef enum logic [4:0] {
        ADD  = 5'd0,
        SUB  = 5'd1,
        AND  = 5'd2,
        OR   = 5'd3,
        XOR  = 5'd4,
        SLL  = 5'd5,
        SRL  = 5'd6,
        MUL  = 5'd8,
        DIV  = 5'd9,
        SQRT = 5'd10
    } func5_t;

endpackage

// File: rtl/fu_scoreboard.sv
// Per-register pending bits; register 0 is never pending. Set wins over clear.
module fu_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_idx,
    input  logic       clr_en,
    input  logic [4:0] clr_idx,
    input  logic [4:0] rd_idx_a,
    input  logic [4:0] rd_idx_b,
    input  logic [4:0] rd_idx_c,
    output logic       rd_pend_a,
    output logic       rd_pend_b,
    output logic       rd_pend_c
);
    logic [31:0] pend_q, pend_d;

    // Next pending vector: retire clears, issue sets, x0 forced clear.
    always_comb begin
        pend_d = pend_q;
        if (clr_en) pend_d[clr_idx] = 1'b0;
        if (set_en) pend_d[set_idx] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // Pending register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign rd_pend_a = pend_q[rd_idx_a];
    assign rd_pend_b = pend_q[rd_idx_b];
    assign rd_pend_c = pend_q[rd_idx_c];
endmodule

// File: rtl/fu_issue_ctrl.sv
// In-order issue control for ALU / pipelined MUL / iterative DIV with a shared
// writeback port. Optional divider path enabled by defining FU_DIV_EN.
module fu_issue_ctrl
    import opcode_pkg::*;
    import fu_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_opc,
    input  logic [4:0] in_func5,
    input  logic [4:0] in_rd,
    input  logic [4:0] in_rs1,
    input  logic [4:0] in_rs2,
    output logic       alu_issue,
    output logic       mul_issue,
    output logic       div_start,
    input  logic       div_done,
    output logic       div_ack,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic [1:0] wb_src,
    output logic       illegal
);
`ifdef FU_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    wb_entry_t  wbq_q [MUL_LAT];
    wb_entry_t  wbq_d [MUL_LAT];
    logic       illegal_q, illegal_d;
    route_t     route;
    logic       rs1_p, rs2_p, rd_p, hazard, fire, div_idle;
    logic [4:0] div_rd;

    assign route  = fu_route(in_opc, in_func5, DIV_EN);
    assign hazard = rs1_p | rs2_p | rd_p;

    fu_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   ((alu_issue | mul_issue | div_start) && (in_rd != 5'd0)),
        .set_idx  (in_rd),
        .clr_en   (wbq_q[0].valid),
        .clr_idx  (wbq_q[0].rd),
        .rd_idx_a (in_rs1),
        .rd_idx_b (in_rs2),
        .rd_idx_c (in_rd),
        .rd_pend_a(rs1_p),
        .rd_pend_b(rs2_p),
        .rd_pend_c(rd_p)
    );

`ifdef FU_DIV_EN
    div_state_t div_state_q, div_state_d;
    logic [4:0] div_rd_q, div_rd_d;

    assign div_ack  = (div_state_q == DIV_BUSY) && div_done && !wbq_q[1].valid;
    assign div_idle = (div_state_q == DIV_IDLE);
    assign div_rd   = div_rd_q;

    // Divider FSM state and captured destination register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_state_q <= DIV_IDLE;
            div_rd_q    <= 5'd0;
        end else begin
            div_state_q <= div_state_d;
            div_rd_q    <= div_rd_d;
        end
    end

    // Divider FSM next state: busy from start until the result is retired.
    always_comb begin
        div_state_d = div_state_q;
        div_rd_d    = div_rd_q;
        case (div_state_q)
            DIV_IDLE: if (div_start) begin
                div_state_d = DIV_BUSY;
                div_rd_d    = in_rd;
            end
            DIV_BUSY: if (div_ack) div_state_d = DIV_IDLE;
            default:  div_state_d = DIV_IDLE;
        endcase
    end
`else
    logic div_unused;
    assign div_unused = div_done;
    assign div_ack    = 1'b0;
    assign div_idle   = 1'b0;
    assign div_rd     = 5'd0;
`endif

    // Accept decision from state and current inputs only; never from in_valid.
    // An ALU result lands in wbq[0], so it waits while wbq[1] or a divider retire would collide.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (route)
                RT_ILL:  in_ready = 1'b1;
                RT_ALU:  in_ready = !hazard && !wbq_q[1].valid && !div_ack;
                RT_MUL:  in_ready = !hazard;
                RT_DIV:  in_ready = !hazard && div_idle;
                default: in_ready = 1'b0;
            endcase
        end
        fire      = in_valid && in_ready;
        alu_issue = fire && (route == RT_ALU);
        mul_issue = fire && (route == RT_MUL);
        div_start = fire && (route == RT_DIV);
        illegal_d = fire && (route == RT_ILL);
    end

    // Writeback queue shifts toward slot 0; MUL enters at the top, ALU/DIV at slot 0.
    always_comb begin
        for (int k = 0; k < MUL_LAT - 1; k++) wbq_d[k] = wbq_q[k+1];
        wbq_d[MUL_LAT-1] = '0;
        if (mul_issue) wbq_d[MUL_LAT-1] = '{valid: 1'b1, rd: in_rd, src: FU_MUL};
        if (alu_issue) wbq_d[0] = '{valid: 1'b1, rd: in_rd, src: FU_ALU};
        if (div_ack)   wbq_d[0] = '{valid: 1'b1, rd: div_rd, src: FU_DIV};
    end

    // Writeback queue and illegal pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) wbq_q[k] <= '0;
            illegal_q <= 1'b0;
        end else begin
            for (int k = 0; k < MUL_LAT; k++) wbq_q[k] <= wbq_d[k];
            illegal_q <= illegal_d;
        end
    end

    assign wb_valid = wbq_q[0].valid;
    assign wb_rd    = wbq_q[0].rd;
    assign wb_src   = wbq_q[0].src;
    assign illegal  = illegal_q;
endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Directed bench for fu_issue_ctrl (MUL_LAT=3): per-cycle vector table plus
// hand-written reset and divider/unhandled sequences.
module tb_fu_issue_ctrl;
    import opcode_pkg::*;
    import fu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_ready;
    logic [2:0] in_opc = 3'd0;
    logic [4:0] in_func5 = 5'd0, in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
    logic       alu_issue, mul_issue, div_start, div_done = 1'b0, div_ack;
    logic       wb_valid, illegal;
    logic [4:0] wb_rd;
    logic [1:0] wb_src;

    int total = 0;
    int bad   = 0;

    fu_issue_ctrl #(.MUL_LAT(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opc(in_opc), .in_func5(in_func5), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .alu_issue(alu_issue), .mul_issue(mul_issue),
        .div_start(div_start), .div_done(div_done), .div_ack(div_ack),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_src(wb_src), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] opc;
        logic [4:0] f5, rd, rs1, rs2;
        logic       rdy, alu, mul, wbv;
        logic [4:0] wbrd;
        logic [1:0] wbsrc;
        logic       ill;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [NV];

    function automatic vec_t mk(logic v, logic [2:0] opc, logic [4:0] f5, logic [4:0] rd,
                                logic [4:0] rs1, logic [4:0] rs2, logic rdy, logic alu,
                                logic mul, logic wbv, logic [4:0] wbrd, logic [1:0] wbsrc,
                                logic ill);
        vec_t r;
        r.v = v; r.opc = opc; r.f5 = f5; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.rdy = rdy; r.alu = alu; r.mul = mul; r.wbv = wbv; r.wbrd = wbrd;
        r.wbsrc = wbsrc; r.ill = ill;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] opc, input logic [4:0] f5,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        in_valid = v; in_opc = opc; in_func5 = f5; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    endtask

    task automatic idle();
        drive(1'b0, R_TYPE, ADD, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // cycle-by-cycle table; registered outputs reflect earlier rows
        tbl[0]  = mk(1, R_TYPE, ADD, 3, 1, 2,   1, 1, 0,  0, 0, FU_ALU, 0);
        tbl[1]  = mk(0, R_TYPE, ADD, 0, 0, 0,   1, 0, 0,  1, 3, FU_ALU, 0);
        tbl[2]  = mk(1, R_TYPE, MUL, 4, 1, 2,   1, 0, 1,  0, 0, FU_ALU, 0);
        tbl[3]  = mk(1, I_TYPE, ADD, 6, 4, 0,   0, 0, 0,  0, 0, FU_ALU, 0);
        tbl[4]  = mk(1, I_TYPE, ADD, 6, 4, 0,   0, 0, 0,  0, 0, FU_ALU, 0);
        tbl[5]  = mk(1, I_TYPE, ADD, 6, 4, 0,   0, 0, 0,  1, 4, FU_MUL, 0);
        tbl[6]  = mk(1, I_TYPE, ADD, 6, 4, 0,   1, 1, 0,  0, 0, FU_ALU, 0);
        tbl[7]  = mk(0, R_TYPE, ADD, 0, 0, 0,   1, 0, 0,  1, 6, FU_ALU, 0);
        tbl[8]  = mk(1, F_TYPE, MUL, 4, 0, 0,   1, 0, 1,  0, 0, FU_ALU, 0);
        tbl[9]  = mk(0, R_TYPE, ADD, 0, 0, 0,   1, 0, 0,  0, 0, FU_ALU, 0);
        tbl[10] = mk(1, R_TYPE, ADD, 5, 1, 2,   0, 0, 0,  0, 0, FU_ALU, 0);
        tbl[11] = mk(1, R_TYPE, ADD, 5, 1, 2,   1, 1, 0,  1, 4, FU_MUL, 0);
        tbl[12] = mk(0, R_TYPE, ADD, 0, 0, 0,   1, 0, 0,  1, 5, FU_ALU, 0);
        tbl[13] = mk(1, X_TYPE, MUL, 9, 0, 0,   1, 0, 1,  0, 0, FU_ALU, 0);
        tbl[14] = mk(1, M_TYPE, ADD, 9, 9, 0,   1, 0, 0,  0, 0, FU_ALU, 0);
        tbl[15] = mk(0, R_TYPE, ADD, 0, 0, 0,   0, 0, 0,  0, 0, FU_ALU, 1);
        tbl[16] = mk(0, R_TYPE, ADD, 0, 0, 0,   1, 0, 0,  1, 9, FU_MUL, 0);
        tbl[17] = mk(1, U_TYPE, MUL, 0, 0, 0,   1, 1, 0,  0, 0, FU_ALU, 0);
        tbl[18] = mk(1, U_TYPE, ADD, 0, 0, 0,   1, 1, 0,  1, 0, FU_ALU, 0);
        tbl[19] = mk(0, R_TYPE, ADD, 0, 0, 0,   1, 0, 0,  1, 0, FU_ALU, 0);
        tbl[20] = mk(1, C_TYPE, ADD, 0, 0, 0,   1, 0, 0,  0, 0, FU_ALU, 0);
        tbl[21] = mk(0, R_TYPE, ADD, 0, 0, 0,   1, 0, 0,  0, 0, FU_ALU, 1);
        tbl[22] = mk(1, R_TYPE, MUL, 12, 1, 0,  1, 0, 1,  0, 0, FU_ALU, 0);
        tbl[23] = mk(1, R_TYPE, MUL, 13, 0, 12, 0, 0, 0,  0, 0, FU_ALU, 0);
        tbl[24] = mk(1, R_TYPE, XOR, 12, 0, 0,  0, 0, 0,  0, 0, FU_ALU, 0);
        tbl[25] = mk(1, R_TYPE, MUL, 13, 0, 12, 0, 0, 0,  1, 12, FU_MUL, 0);
        tbl[26] = mk(1, R_TYPE, MUL, 13, 0, 12, 1, 0, 1,  0, 0, FU_ALU, 0);
        tbl[27] = mk(1, D_TYPE, ADD, 13, 0, 0,  1, 0, 0,  0, 0, FU_ALU, 0);
        tbl[28] = mk(0, R_TYPE, ADD, 0, 0, 0,   0, 0, 0,  0, 0, FU_ALU, 1);
        tbl[29] = mk(0, R_TYPE, ADD, 0, 0, 0,   1, 0, 0,  1, 13, FU_MUL, 0);

        // reset state: outputs low while rst held, even with an offer present
        drive(1'b1, R_TYPE, ADD, 5'd3, 5'd0, 5'd0);
        #2;
        chk("rst in_ready", in_ready, 0);
        chk("rst alu_issue", alu_issue, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst illegal", illegal, 0);
        chk("rst div_ack", div_ack, 0);
        idle();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].opc, tbl[i].f5, tbl[i].rd, tbl[i].rs1, tbl[i].rs2);
            #1;
            chk($sformatf("row%0d in_ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("row%0d alu_issue", i), alu_issue, tbl[i].alu);
            chk($sformatf("row%0d mul_issue", i), mul_issue, tbl[i].mul);
            chk($sformatf("row%0d div_start", i), div_start, 0);
            chk($sformatf("row%0d wb_valid", i), wb_valid, tbl[i].wbv);
            chk($sformatf("row%0d wb_rd", i), wb_rd, tbl[i].wbrd);
            chk($sformatf("row%0d wb_src", i), wb_src, tbl[i].wbsrc);
            chk($sformatf("row%0d illegal", i), illegal, tbl[i].ill);
        end

        // drain
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
        end

        // reset in flight: MUL rd=4 dropped, ADD rs1=4 issues right after reset
        @(negedge clk);
        drive(1'b1, R_TYPE, MUL, 5'd4, 5'd0, 5'd0);
        #1;
        chk("rstseq mul_issue", mul_issue, 1);
        @(negedge clk);
        drive(1'b1, R_TYPE, ADD, 5'd5, 5'd4, 5'd0);
        rst = 1'b1;
        #1;
        chk("rstseq in_ready held", in_ready, 0);
        chk("rstseq alu held", alu_issue, 0);
        chk("rstseq wb_valid held", wb_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstseq in_ready after", in_ready, 1);
        chk("rstseq alu after", alu_issue, 1);
        chk("rstseq wb_valid after", wb_valid, 0);
        @(negedge clk);
        idle();
        #1;
        chk("rstseq wb_valid add", wb_valid, 1);
        chk("rstseq wb_rd add", wb_rd, 5);
        chk("rstseq wb_src add", wb_src, FU_ALU);
        @(negedge clk);
        #1;
        chk("rstseq wb_valid late", wb_valid, 0);

`ifdef FU_DIV_EN
        // DIV rd=7, second DIV waits until the first retires
        @(negedge clk);
        drive(1'b1, R_TYPE, DIV, 5'd7, 5'd1, 5'd2);
        #1;
        chk("div0 in_ready", in_ready, 1);
        chk("div0 div_start", div_start, 1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            drive(1'b1, R_TYPE, DIV, 5'd8, 5'd1, 5'd2);
            #1;
            chk($sformatf("div%0d in_ready", k), in_ready, 0);
            chk($sformatf("div%0d div_ack", k), div_ack, 0);
        end
        @(negedge clk);
        div_done = 1'b1;
        #1;
        chk("div10 div_ack", div_ack, 1);
        chk("div10 in_ready", in_ready, 0);
        @(negedge clk);
        div_done = 1'b0;
        #1;
        chk("div11 in_ready", in_ready, 1);
        chk("div11 div_start", div_start, 1);
        chk("div11 wb_valid", wb_valid, 1);
        chk("div11 wb_rd", wb_rd, 7);
        chk("div11 wb_src", wb_src, FU_DIV);
        @(negedge clk);
        idle();
        div_done = 1'b1;
        #1;
        chk("div12 div_ack", div_ack, 1);
        @(negedge clk);
        div_done = 1'b0;
        #1;
        chk("div13 wb_rd", wb_rd, 8);
        chk("div13 wb_src", wb_src, FU_DIV);
`else
        // divider absent: SQRT and DIV are unhandled
        @(negedge clk);
        drive(1'b1, R_TYPE, SQRT, 5'd10, 5'd0, 5'd0);
        div_done = 1'b1;
        #1;
        chk("sqrt in_ready", in_ready, 1);
        chk("sqrt div_start", div_start, 0);
        chk("sqrt alu_issue", alu_issue, 0);
        chk("sqrt div_ack", div_ack, 0);
        @(negedge clk);
        drive(1'b1, X_TYPE, DIV, 5'd11, 5'd0, 5'd0);
        #1;
        chk("sqrt illegal", illegal, 1);
        chk("div in_ready", in_ready, 1);
        chk("div div_start", div_start, 0);
        @(negedge clk);
        idle();
        div_done = 1'b0;
        #1;
        chk("div illegal", illegal, 1);
        chk("sqrt wb_valid", wb_valid, 0);
        @(negedge clk);
        #1;
        chk("div illegal end", illegal, 0);
        chk("div wb_valid", wb_valid, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fu_issue_ctrl.md
FU_ISSUE_CTRL -- requirements
Module: fu_issue_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, meaning multiplier issue-to-writeback latency in cycles (legal >= 2).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous reset, active-high.
REQ-004 SHALL have port in_valid  in  1  decoded instruction offered.
REQ-005 SHALL have port in_ready  out  1  instruction accepted when in_valid && in_ready.
REQ-006 SHALL have port in_opc  in  3  opc_t.
REQ-007 SHALL have port in_func5  in  5  func5_t.
REQ-008 SHALL have ports in_rd, in_rs1, in_rs2  in  5 each  register indices.
REQ-009 SHALL have ports alu_issue, mul_issue, div_start  out  1 each  single-cycle issue pulses, same cycle as handshake.
REQ-010 SHALL have port div_done  in  1  divider result ready, held until div_ack.
REQ-011 SHALL have port div_ack  out  1  divider result consumed this cycle.
REQ-012 SHALL have ports wb_valid out 1, wb_rd out 5, wb_src out 2 (fu_sel_t)  registered writeback command.
REQ-013 SHALL have port illegal  out  1  one-cycle pulse.

Function
REQ-014 Routing: opc R/I/F/X_TYPE: func5 MUL -> MUL; DIV, SQRT -> DIV; else ALU; U_TYPE -> ALU; M/D/C_TYPE -> unhandled.
REQ-015 Unhandled: in_ready=1 regardless of hazards; no issue, no writeback; illegal=1 in cycle T+1.
REQ-016 Writeback queue wbq[0..MUL_LAT-1] of {valid, rd, src}; each edge wbq[k] <= wbq[k+1], top slot empties; outputs wb_* = wbq[0].
REQ-017 ALU issue at T writes wbq[0] -> wb_valid at T+1; MUL issue at T writes wbq[MUL_LAT-1] -> wb_valid at T+MUL_LAT.
REQ-018 ALU issue stalls (in_ready=0) while wbq[1].valid; MUL never collides.
REQ-019 Scoreboard: pending bit per register, set at issue for rd!=0, cleared at the edge ending a wb_valid cycle for wb_rd.
REQ-020 Hazard stall: any nonzero rs1, rs2 or rd pending -> in_ready=0; no bypass; register 0 never pending.
REQ-021 DIV FSM IDLE -> BUSY on div_start; BUSY -> IDLE on div_ack; DIV instruction stalls unless IDLE.
REQ-022 div_ack = BUSY && div_done && !wbq[1].valid; on div_ack wbq[0] <= {1, held div rd, FU_DIV}; div retire takes priority, stalling any ALU issue that cycle.
REQ-023 At most one handshake per cycle; in_ready depends on in_valid-independent state and current inputs only (no combinational loop via in_ready).

Reset
REQ-024 rst asserted anytime: wbq, pending bits cleared, FSM IDLE, all outputs 0 immediately; in-flight results are discarded.
REQ-025 First handshake possible in the first cycle after rst deasserts.

Configuration
REQ-026 Macro FU_DIV_EN defined: DIV path, FSM, div_start/div_ack active as above.
REQ-027 FU_DIV_EN undefined: DIV/SQRT treated as unhandled (REQ-015); div_start, div_ack tied 0; no FSM logic; ports retained.

Structure
REQ-028 fu_sel_t enum {FU_ALU=0, FU_MUL=1, FU_DIV=2} and wb entry struct SHALL live in shared package fu_pkg; opc_t/func5_t come from opcode_pkg.
REQ-029 Scoreboard SHALL be sub-module fu_scoreboard (set/clear ports, three read ports).

Verification (MUL_LAT=3)
REQ-030 ADD rd=3 at T -> alu_issue T; wb_valid T+1, wb_rd=3, wb_src=FU_ALU.
REQ-031 MUL rd=4 at T, ADD rd=5 offered T+2 -> in_ready=0 at T+2, ADD issues T+3; wb rd=4 at T+3, rd=5 at T+4.
REQ-032 MUL rd=4 at T, ADD rs1=4 offered T+1 -> stall through T+3, issue T+4.
REQ-033 DIV rd=7 at T, second DIV offered T+1, div_done at T+10 -> div_ack T+10, wb rd=7 src=FU_DIV at T+11, second DIV issues T+11; with FU_DIV_EN undefined, SQRT -> illegal at T+1, no wb.
REQ-034 M_TYPE at T while rd pending -> accepted T, illegal T+1 only.
REQ-035 rst pulse at T+1 after MUL rd=4 at T -> wb_valid stays 0, pending[4]=0, ADD rs1=4 issues first cycle after reset.
